// File: rtl/sockit_spi_pkg.sv
// Shared FSM state type and AXI response codes for the SoCkit SPI DMA.
package sockit_spi_pkg;

    typedef enum logic [1:0] {
        IDL = 2'd0,
        GET = 2'd1,
        WR  = 2'd2,
        BRS = 2'd3
    } dma_sts_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [3:0] WSTRB_ALL = 4'hF;
    localparam logic [2:0] PROT_NONE = 3'b000;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with initiator (m) and target (t) views.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport m (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport t (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/sockit_spi_if.sv
// SPI read-data stream: the source drives vld/dat, the sink drives rdy.
interface sockit_spi_if #(
    parameter int DW = 32
);
    logic          vld;
    logic [DW-1:0] dat;
    logic          rdy;

    modport s (input vld, input dat, output rdy);
    modport m (output vld, output dat, input rdy);
endinterface

// File: rtl/sockit_spi_dma.sv
// Moves words from the SPI read stream to consecutive AXI4-Lite addresses, one write at a time.
// Optional: define SOCKIT_SPI_DMA_ABORT_EN to stop with err on a non-OKAY write response.
module sockit_spi_dma
    import sockit_spi_pkg::*;
#(
    parameter int AW = 32,
    parameter int LW = 16
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          start,
    input  logic [AW-1:0] adr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    sockit_spi_if.s       sdr,
    axi4_lite_if.m        axi
);

    dma_sts_t      sts;
    logic [AW-1:0] adr_q;
    logic [LW-1:0] cnt;
    logic [31:0]   dat_q;
    logic          awvalid;
    logic          wvalid;
    logic          bready;
    logic          rdy;
    logic          aw_ok;
    logic          w_ok;
    logic          abort;

    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a);
        return a + AW'(4);
    endfunction

    // A channel counts as finished once its valid has dropped or is being accepted now.
    assign aw_ok = !awvalid || axi.awready;
    assign w_ok  = !wvalid  || axi.wready;

    assign sdr.rdy     = rdy;
    assign axi.awvalid = awvalid;
    assign axi.awaddr  = adr_q;
    assign axi.awprot  = PROT_NONE;
    assign axi.wvalid  = wvalid;
    assign axi.wdata   = dat_q;
    assign axi.wstrb   = WSTRB_ALL;
    assign axi.bready  = bready;
    assign axi.arvalid = 1'b0;
    assign axi.araddr  = '0;
    assign axi.arprot  = PROT_NONE;
    assign axi.rready  = 1'b0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sts     <= IDL;
            busy    <= 1'b0;
            done    <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            rdy     <= 1'b0;
            adr_q   <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (sts)
                IDL: begin
                    if (start) begin
                        adr_q <= {adr[AW-1:2], 2'b00};
                        cnt   <= len;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            sts  <= GET;
                            busy <= 1'b1;
                            rdy  <= 1'b1;
                        end
                    end
                end
                GET: begin
                    if (sdr.vld) begin
                        rdy     <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        sts     <= WR;
                    end
                end
                WR: begin
                    if (axi.awready) awvalid <= 1'b0;
                    if (axi.wready)  wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        sts    <= BRS;
                        bready <= 1'b1;
                    end
                end
                BRS: begin
                    if (axi.bvalid) begin
                        bready <= 1'b0;
                        adr_q  <= next_adr(adr_q);
                        cnt    <= cnt - LW'(1);
                        if (abort || cnt == LW'(1)) begin
                            sts  <= IDL;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            sts <= GET;
                            rdy <= 1'b1;
                        end
                    end
                end
                default: sts <= IDL;
            endcase
        end
    end

    // Payload register: written only on the stream handshake, no reset needed.
    always_ff @(posedge ACLK) begin
        if (sts == GET && sdr.vld && rdy) dat_q <= sdr.dat;
    end

`ifdef SOCKIT_SPI_DMA_ABORT_EN
    logic err_q;

    assign abort = (axi.bresp != OKAY);
    assign err   = err_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_q <= 1'b0;
        end else if (sts == IDL && start) begin
            err_q <= 1'b0;
        end else if (sts == BRS && axi.bvalid && abort) begin
            err_q <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{adr[1:0], axi.arready, axi.rvalid, axi.rdata, axi.rresp};
`else
    assign abort = 1'b0;
    assign err   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{adr[1:0], axi.bresp, axi.arready, axi.rvalid, axi.rdata, axi.rresp};
`endif

endmodule
